div_share_arb: RTL and testbench

Round-robin scheduler that shares one pipelined `divider_man` instance (N-bit dividend, M-bit divisor, fixed latency LAT) between NREQ requesters. It accepts one division per cycle from the granted requester and tags each issue so the result is routed back to its owner. Each requester gets a one-entry result buffer with a valid/ready handshake. It sits between the score-line channels and the shared divider.

---
 rtl/div_share_arb.sv | 136 +++++++++++++
 tb/tb_div_share_arb.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_arb.sv
// rtl/div_share_arb.sv - round-robin sharing of one pipelined divider among NREQ requesters
// Results are routed back through a tag pipe aligned with the divider latency.
module div_share_arb #(
  parameter int NREQ = 4,
  parameter int N    = 19,
  parameter int M    = 11,
  parameter int LAT  = 19
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_dividend,
  input  logic [NREQ*M-1:0] req_divisor,
  output logic [NREQ-1:0]   resp_valid,
  input  logic [NREQ-1:0]   resp_ready,
  output logic [NREQ*N-1:0] resp_quot,
  output logic [NREQ*M-1:0] resp_rem,
  output logic [NREQ-1:0]   resp_dz,
  output logic              div_data_rdy,
  output logic [N-1:0]      div_dividend,
  output logic [M-1:0]      div_divisor,
  input  logic              div_res_rdy,
  input  logic [N-1:0]      div_merchant,
  input  logic [M-1:0]      div_remainder,
  output logic              busy,
  output logic              err
);
  localparam int IDW = $clog2(NREQ);

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int k);
    return IDW'((int'(base) + k) % NREQ);
  endfunction

  logic [NREQ-1:0] outst, eligible;
  logic [IDW-1:0]  rr, gnt_id, iss_id;
  logic            gnt_any, xfer, iss_dz;
  logic [N-1:0]    sel_a;
  logic [M-1:0]    sel_b;

  logic [LAT:1]    tag_v, tag_dz;
  logic [IDW-1:0]  tag_id [1:LAT];
  logic            cap, cap_dz;
  logic [IDW-1:0]  cap_id;

  assign eligible = req_valid & ~outst;

  // Walk downwards so the eligible requester closest to rr wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (eligible[wrap_add(rr, k)]) begin
        gnt_any = 1'b1;
        gnt_id  = wrap_add(rr, k);
      end
    end
  end

  assign req_ready = (gnt_any && rstn) ? (NREQ'(1) << gnt_id) : '0;
  assign xfer      = |req_ready;
  assign sel_a     = req_dividend[int'(gnt_id) * N +: N];
  assign sel_b     = req_divisor[int'(gnt_id) * M +: M];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_data_rdy <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      iss_id       <= '0;
      iss_dz       <= 1'b0;
      rr           <= '0;
    end else begin
      div_data_rdy <= xfer;
      if (xfer) begin
        div_dividend <= sel_a;
        div_divisor  <= (sel_b == '0) ? M'(1) : sel_b;
        iss_id       <= gnt_id;
        iss_dz       <= (sel_b == '0);
        rr           <= wrap_add(gnt_id, 1);
      end
    end
  end

  // Stage 1 is fed from the issue register, so stage LAT lines up with div_res_rdy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_v  <= '0;
      tag_dz <= '0;
      for (int k = 1; k <= LAT; k++) tag_id[k] <= '0;
    end else begin
      tag_v[1]  <= div_data_rdy;
      tag_dz[1] <= iss_dz;
      tag_id[1] <= iss_id;
      for (int k = 2; k <= LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_dz[k] <= tag_dz[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  assign cap    = tag_v[LAT];
  assign cap_id = tag_id[LAT];
  assign cap_dz = tag_dz[LAT];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      outst      <= '0;
      resp_valid <= '0;
      resp_quot  <= '0;
      resp_rem   <= '0;
      resp_dz    <= '0;
      err        <= 1'b0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) outst[i] <= 1'b1;
        else if (resp_valid[i] && resp_ready[i]) outst[i] <= 1'b0;

        if (cap && cap_id == IDW'(i)) begin
          resp_valid[i]        <= 1'b1;
          resp_dz[i]           <= cap_dz;
          resp_quot[i*N +: N]  <= cap_dz ? {N{1'b1}} : div_merchant;
          resp_rem[i*M +: M]   <= cap_dz ? '0 : div_remainder;
        end else if (resp_valid[i] && resp_ready[i]) begin
          resp_valid[i] <= 1'b0;
        end
      end
      // A live tag without a divider result means the latency assumption broke.
      if (cap && !div_res_rdy) err <= 1'b1;
    end
  end

  assign busy = |outst;

endmodule

// File: tb/tb_div_share_arb.sv
// tb/tb_div_share_arb.sv - self-checking bench for div_share_arb with a behavioural divider
module tb_div_share_arb;
  localparam int NREQ = 4, N = 19, M = 11, LAT = 19;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn;
  logic [NREQ-1:0]   req_valid, req_ready, resp_valid, resp_ready, resp_dz;
  logic [NREQ*N-1:0] req_dividend, resp_quot;
  logic [NREQ*M-1:0] req_divisor, resp_rem;
  logic              div_data_rdy, div_res_rdy, busy, err;
  logic [N-1:0]      div_dividend, div_merchant;
  logic [M-1:0]      div_divisor, div_remainder;

  div_share_arb #(.NREQ(NREQ), .N(N), .M(M), .LAT(LAT)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_quot(resp_quot), .resp_rem(resp_rem), .resp_dz(resp_dz),
    .div_data_rdy(div_data_rdy), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_res_rdy(div_res_rdy), .div_merchant(div_merchant), .div_remainder(div_remainder),
    .busy(busy), .err(err)
  );

  // Behavioural divider: results and res_rdy delayed LAT cycles; one chosen op can lose res_rdy.
  logic [LAT-1:0] dm_v = '0;
  logic [N-1:0]   dm_q [LAT];
  logic [M-1:0]   dm_r [LAT];
  int             dm_cnt = 0;
  int             drop_idx = -1;

  always @(posedge clk) begin
    dm_v     <= {dm_v[LAT-2:0], div_data_rdy && (dm_cnt != drop_idx)};
    dm_q[0]  <= (div_divisor == '0) ? '1 : div_dividend / N'(div_divisor);
    dm_r[0]  <= (div_divisor == '0) ? '0 : M'(div_dividend % N'(div_divisor));
    for (int k = 1; k < LAT; k++) begin
      dm_q[k] <= dm_q[k-1];
      dm_r[k] <= dm_r[k-1];
    end
    if (div_data_rdy) dm_cnt <= dm_cnt + 1;
  end

  assign div_res_rdy   = dm_v[LAT-1];
  assign div_merchant  = dm_q[LAT-1];
  assign div_remainder = dm_r[LAT-1];

  // Scoreboard / reference model state
  int              nvec = 0, nerr = 0, cyc = 0;
  bit              chk_on = 0;
  int              m_rr = 0;
  logic [NREQ-1:0] m_outst = '0, pend = '0, last_xfer = '0;
  logic [N-1:0]    e_q [NREQ];
  logic [M-1:0]    e_r [NREQ];
  logic [NREQ-1:0] e_dz;
  int              t_x [NREQ], t_hs [NREQ];

  typedef struct {
    logic [N-1:0] a;
    logic [M-1:0] b;
    logic [N-1:0] q;
    logic [M-1:0] r;
    logic         dz;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [NREQ-1:0] exp_grant();
    for (int k = 0; k < NREQ; k++)
      if (req_valid[(m_rr + k) % NREQ] && !m_outst[(m_rr + k) % NREQ])
        return NREQ'(1) << ((m_rr + k) % NREQ);
    return '0;
  endfunction

  // One clock: check the grant, record transfers/handshakes, score newly arrived results.
  task automatic tick();
    logic [NREQ-1:0] xf, hs;
    logic [N-1:0] a;
    logic [M-1:0] b;
    #2;
    xf = req_valid & req_ready;
    hs = resp_valid & resp_ready;
    if (chk_on) chk("grant", req_ready, exp_grant());
    for (int i = 0; i < NREQ; i++) begin
      if (xf[i]) begin
        a = req_dividend[i*N +: N];
        b = req_divisor[i*M +: M];
        e_dz[i] = (b == '0);
        e_q[i]  = (b == '0) ? '1 : a / N'(b);
        e_r[i]  = (b == '0) ? '0 : M'(a % N'(b));
        m_rr = (i + 1) % NREQ;
        m_outst[i] = 1'b1;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    last_xfer = xf;
    for (int i = 0; i < NREQ; i++) begin
      if (xf[i]) begin pend[i] = 1'b1; t_x[i] = cyc; end
      if (hs[i]) begin m_outst[i] = 1'b0; t_hs[i] = cyc; end
      if (pend[i] && resp_valid[i]) begin
        pend[i] = 1'b0;
        chk("latency", cyc - t_x[i], LAT + 1);
        chk("quot", resp_quot[i*N +: N], e_q[i]);
        chk("rem", resp_rem[i*M +: M], e_r[i]);
        chk("dz", resp_dz[i], e_dz[i]);
      end
    end
  endtask

  task automatic issue(input int i, input logic [N-1:0] a, input logic [M-1:0] b);
    req_dividend[i*N +: N] = a;
    req_divisor[i*M +: M]  = b;
    req_valid[i] = 1'b1;
    last_xfer = '0;
    for (int w = 0; w < 100 && !last_xfer[i]; w++) tick();
    chk("issue_done", last_xfer[i], 1);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_resp(input int i);
    for (int w = 0; w < 80 && !resp_valid[i]; w++) tick();
    chk("resp_arrived", resp_valid[i], 1);
  endtask

  task automatic drain();
    req_valid = '0;
    resp_ready = '1;
    for (int w = 0; w < 200 && (busy || pend != '0); w++) tick();
    chk("drain_busy", busy, 0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_div_data_rdy"}, div_data_rdy, 0);
    chk({tag, "_div_dividend"}, div_dividend, 0);
    chk({tag, "_div_divisor"}, div_divisor, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_quot"}, resp_quot, 0);
    chk({tag, "_resp_rem"}, resp_rem, 0);
    chk({tag, "_resp_dz"}, resp_dz, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] q1, aq [NREQ];
    logic [M-1:0] ar [NREQ];
    int t0, t_err, n_oth;

    tbl[0] = '{19'd264,    11'd8,    19'd33,      11'd0,   1'b0};
    tbl[1] = '{19'd64,     11'd8,    19'd8,       11'd0,   1'b0};
    tbl[2] = '{19'd4514,   11'd66,   19'd68,      11'd26,  1'b0};
    tbl[3] = '{19'd100,    11'd7,    19'd14,      11'd2,   1'b0};
    tbl[4] = '{19'd4514,   11'd0,    19'h7FFFF,   11'd0,   1'b1};
    tbl[5] = '{19'd0,      11'd5,    19'd0,       11'd0,   1'b0};
    tbl[6] = '{19'd524287, 11'd1,    19'd524287,  11'd0,   1'b0};
    tbl[7] = '{19'd524287, 11'd2047, 19'd256,     11'd255, 1'b0};
    tbl[8] = '{19'd5,      11'd2047, 19'd0,       11'd5,   1'b0};
    tbl[9] = '{19'd1000,   11'd3,    19'd333,     11'd1,   1'b0};

    rstn = 1'b0;
    req_valid = '0;
    resp_ready = '1;
    req_dividend = '0;
    req_divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    rstn = 1'b1;
    chk_on = 1;
    tick();

    // All four valid continuously from rr=0
    req_dividend = {19'd100, 19'd4514, 19'd64, 19'd264};
    req_divisor  = {11'd7, 11'd66, 11'd8, 11'd8};
    aq = '{19'd33, 19'd8, 19'd68, 19'd14};
    ar = '{11'd0, 11'd0, 11'd26, 11'd2};
    req_valid = '1;
    for (int k = 0; k < NREQ; k++) begin
      tick();
      chk("grant_order", last_xfer, NREQ'(1) << k);
    end
    t0 = t_x[0];
    for (int k = 0; k < NREQ; k++) begin
      wait_resp(k);
      chk("port_quot", resp_quot[k*N +: N], aq[k]);
      chk("port_rem", resp_rem[k*M +: M], ar[k]);
    end
    for (int w = 0; w < 40 && t_x[0] == t0; w++) tick();
    chk("regrant0_seen", t_x[0] != t0, 1);
    chk("regrant0_after_hs", t_x[0] - t_hs[0], 1);
    drain();

    // Backpressure on requester 1 while the others keep running
    resp_ready = 4'b1101;
    req_valid = '1;
    wait_resp(1);
    q1 = resp_quot[N +: N];
    n_oth = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      chk("bp_ready1", req_ready[1], 0);
      chk("bp_hold1", resp_quot[N +: N], q1);
      chk("bp_busy", busy, 1);
      if ((last_xfer & 4'b1101) != '0) n_oth++;
    end
    chk("bp_others_served", n_oth >= 3, 1);
    drain();

    // Table of single operations rotating over requesters
    for (int v = 0; v < 10; v++) begin
      issue(v % NREQ, tbl[v].a, tbl[v].b);
      chk("tbl_issue_rdy", div_data_rdy, 1);
      chk("tbl_issue_a", div_dividend, tbl[v].a);
      chk("tbl_issue_b", div_divisor, (tbl[v].b == '0) ? M'(1) : tbl[v].b);
      wait_resp(v % NREQ);
      chk("tbl_quot", resp_quot[(v % NREQ)*N +: N], tbl[v].q);
      chk("tbl_rem", resp_rem[(v % NREQ)*M +: M], tbl[v].r);
      chk("tbl_dz", resp_dz[v % NREQ], tbl[v].dz);
      chk("tbl_err", err, 0);
      tick();
    end

    // Divider drops res_rdy for one op
    drop_idx = dm_cnt;
    issue(3, 19'd1000, 11'd7);
    chk("err_before", err, 0);
    t_err = -1;
    for (int w = 0; w < 40 && !resp_valid[3]; w++) begin
      tick();
      if (err && t_err < 0) t_err = cyc;
    end
    chk("err_resp", resp_valid[3], 1);
    chk("err_edge", t_err, t_x[3] + LAT + 1);
    repeat (10) tick();
    chk("err_sticky", err, 1);

    // Reset with three ops in flight
    req_dividend = {19'd0, 19'd300, 19'd200, 19'd100};
    req_divisor  = {11'd1, 11'd3, 11'd2, 11'd9};
    req_valid = 4'b0111;
    repeat (3) tick();
    req_valid = '0;
    repeat (4) tick();
    rstn = 1'b0;
    #1;
    check_reset("midrst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    m_outst = '0;
    pend = '0;
    m_rr = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      chk("stale_resp_valid", resp_valid, 0);
      chk("stale_err", err, 0);
    end
    issue(2, 19'd4514, 11'd66);
    wait_resp(2);
    chk("post_rst_quot", resp_quot[2*N +: N], 68);
    chk("post_rst_rem", resp_rem[2*M +: M], 26);
    drain();

    // Randomized traffic against the scoreboard
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (last_xfer[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_dividend[i*N +: N] = N'($urandom);
          req_divisor[i*M +: M]  = ($urandom_range(0, 7) == 0) ? '0 : M'($urandom);
          req_valid[i] = 1'b1;
        end
        resp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      tick();
    end
    drain();
    chk("final_pend", pend, 0);
    chk("final_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
